// File: rtl/msu_fill_sched_pkg.sv
// msu_pkg: shared types and defaults for the MSU buffer refill scheduler.
// Build option MSU_UNDERRUN_CNT_EN is consumed by msu_fill_sched.
package msu_pkg;

   localparam int HALF_BYTES_DEFAULT = 8192;
   localparam int ADDR_W_DEFAULT     = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEEK0  = 3'd1,
      ST_SEEK1  = 3'd2,
      ST_STREAM = 3'd3,
      ST_REFILL = 3'd4,
      ST_DRAIN  = 3'd5
   } msu_fill_state_t;

endpackage

// File: rtl/msu_fill_sched_ack_sync.sv
// msu_ack_sync: brings the MCU fill acknowledge into the clkin domain and
// provides one-cycle strobes on each edge of the synchronized level.
module msu_ack_sync (
   input  logic clkin,
   input  logic rst_n,
   input  logic mcu_ack,
   output logic ack_s,
   output logic ack_rise,
   output logic ack_fall
);

   logic ack_meta_p0;
   logic ack_s_p1;
   logic ack_s_p2;

   // two flops for metastability, a third to detect edges of ack_s
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         ack_meta_p0 <= 1'b0;
         ack_s_p1    <= 1'b0;
         ack_s_p2    <= 1'b0;
      end else begin
         ack_meta_p0 <= mcu_ack;
         ack_s_p1    <= ack_meta_p0;
         ack_s_p2    <= ack_s_p1;
      end
   end

   assign ack_s    = ack_s_p1;
   assign ack_rise = ack_s_p1 & ~ack_s_p2;
   assign ack_fall = ~ack_s_p1 & ack_s_p2;

endmodule

// File: rtl/msu_fill_sched.sv
// msu_fill_sched: double-buffer refill scheduler for the 16 KiB MSU data buffer.
// Define MSU_UNDERRUN_CNT_EN to build the saturating underrun counter.
module msu_fill_sched
   import msu_pkg::*;
#(
   parameter int HALF_BYTES = HALF_BYTES_DEFAULT,
   parameter int ADDR_W     = ADDR_W_DEFAULT
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              seek_start,
   input  logic [ADDR_W-1:0] seek_addr,
   input  logic              rd_half,
   input  logic              mcu_ack,
   output logic              mcu_req,
   output logic              fill_half,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              busy_set,
   output logic              busy_clr,
   output logic              underrun,
   output logic [7:0]        underrun_cnt
);

   msu_fill_state_t   state;
   msu_fill_state_t   state_n;
   logic [ADDR_W-1:0] next_addr;
   logic              cur_half;
   logic              pend_half;
   logic              pend_flag;
   logic              hs_ack;
   logic              seek_p0;
   logic              seek_p1;
   logic              rd_p0;
   logic              rd_p1;
   logic              ack_s;
   logic              ack_rise;
   logic              ack_fall;
   logic              seek_go;
   logic              in_fill;
   logic              in_flight;
   logic              fill_done;
   logic              req_set;
   logic              stream_go;
   logic              rd_toggle;
   logic              urun_evt;

   msu_ack_sync u_ack_sync (
      .clkin    (clkin),
      .rst_n    (rst_n),
      .mcu_ack  (mcu_ack),
      .ack_s    (ack_s),
      .ack_rise (ack_rise),
      .ack_fall (ack_fall)
   );

   // hs_ack guards against a stale ack falling edge left over from an abandoned cycle
   assign seek_go   = seek_p0 & ~seek_p1 & enable;
   assign in_fill   = (state == ST_SEEK0) || (state == ST_SEEK1) || (state == ST_REFILL);
   assign in_flight = mcu_req | ack_s;
   assign fill_done = in_fill & ack_fall & hs_ack;
   assign req_set   = in_fill & enable & ~seek_go & ~in_flight & ~hs_ack;
   assign stream_go = (state == ST_STREAM) & enable & ~seek_go &
                      ((rd_p0 != cur_half) | pend_flag);
   assign rd_toggle = rd_p0 ^ rd_p1;
   assign urun_evt  = (state == ST_REFILL) & enable & ~seek_go & rd_toggle &
                      (rd_p0 == pend_half);
   assign busy_set  = seek_go;
   assign busy_clr  = (state == ST_SEEK1) & fill_done & ~seek_go;

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: begin
            if (seek_go)
               state_n = ST_SEEK0;
         end
         ST_SEEK0, ST_SEEK1, ST_REFILL: begin
            if (seek_go)
               state_n = in_flight ? ST_DRAIN : ST_SEEK0;
            else if (!enable && !in_flight)
               state_n = ST_IDLE;
            else if (fill_done)
               state_n = (state == ST_SEEK0) ? ST_SEEK1 : ST_STREAM;
         end
         ST_STREAM: begin
            if (seek_go)
               state_n = ST_SEEK0;
            else if (!enable)
               state_n = ST_IDLE;
            else if (stream_go)
               state_n = ST_REFILL;
         end
         ST_DRAIN: begin
            if (!in_flight)
               state_n = enable ? ST_SEEK0 : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // input registers, handshake and buffer bookkeeping
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         seek_p0   <= 1'b0;
         seek_p1   <= 1'b0;
         rd_p0     <= 1'b0;
         rd_p1     <= 1'b0;
         mcu_req   <= 1'b0;
         fill_half <= 1'b0;
         fill_addr <= '0;
         next_addr <= '0;
         cur_half  <= 1'b0;
         pend_half <= 1'b0;
         pend_flag <= 1'b0;
         hs_ack    <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state   <= state_n;
         seek_p0 <= seek_start;
         seek_p1 <= seek_p0;
         rd_p0   <= rd_half;
         rd_p1   <= rd_p0;

         if (req_set) begin
            mcu_req   <= 1'b1;
            fill_half <= (state == ST_SEEK0) ? 1'b0 :
                         (state == ST_SEEK1) ? 1'b1 : pend_half;
            fill_addr <= next_addr;
         end else if (mcu_req && ack_rise) begin
            mcu_req <= 1'b0;
         end

         if (mcu_req && ack_rise)
            hs_ack <= 1'b1;
         else if (ack_fall)
            hs_ack <= 1'b0;

         if (seek_go)
            next_addr <= seek_addr;
         else if (fill_done)
            next_addr <= next_addr + ADDR_W'(HALF_BYTES);

         // the refill target is always the half the SNES is not reading
         if (busy_clr) begin
            cur_half <= rd_p0;
         end else if (stream_go) begin
            cur_half  <= rd_p0;
            pend_half <= ~rd_p0;
         end

         if (seek_go || !enable || stream_go)
            pend_flag <= 1'b0;
         else if ((state == ST_REFILL) && rd_toggle)
            pend_flag <= 1'b1;

         if (seek_go)
            underrun <= 1'b0;
         else if (urun_evt)
            underrun <= 1'b1;
      end
   end

`ifdef MSU_UNDERRUN_CNT_EN
   logic [7:0] urun_cnt;

   always_ff @(posedge clkin) begin
      if (!rst_n)
         urun_cnt <= 8'h00;
      else if (seek_go)
         urun_cnt <= 8'h00;
      else if (urun_evt && (urun_cnt != 8'hFF))
         urun_cnt <= urun_cnt + 8'h01;
   end

   assign underrun_cnt = urun_cnt;
`else
   assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_msu_fill_sched.sv
// tb_msu_fill_sched: directed sequence with randomized addresses, gaps and ack
// delays; expected fill halves/offsets come from a simple file-offset model.
module tb_msu_fill_sched;

   localparam logic [31:0] H = 32'h0000_2000;

   logic        clkin = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        seek_start;
   logic [31:0] seek_addr;
   logic        rd_half;
   logic        mcu_ack;
   logic        mcu_req;
   logic        fill_half;
   logic [31:0] fill_addr;
   logic        busy_set;
   logic        busy_clr;
   logic        underrun;
   logic [7:0]  underrun_cnt;

   int checks   = 0;
   int failures = 0;
   int bset_cyc = 0;
   int bclr_cyc = 0;
   int stab_err = 0;
   logic        req_prev = 1'b0;
   logic [31:0] lat_addr = 32'h0;
   logic        lat_half = 1'b0;

   logic [31:0] mn;
   logic [31:0] nb;
   logic        vac;
   logic        seen;
   int          bs0;
   int          bc0;
   logic [7:0]  exp_cnt1;
   logic [7:0]  exp_sat;

   msu_fill_sched #(.HALF_BYTES(8192), .ADDR_W(32)) dut (
      .clkin        (clkin),
      .rst_n        (rst_n),
      .enable       (enable),
      .seek_start   (seek_start),
      .seek_addr    (seek_addr),
      .rd_half      (rd_half),
      .mcu_ack      (mcu_ack),
      .mcu_req      (mcu_req),
      .fill_half    (fill_half),
      .fill_addr    (fill_addr),
      .busy_set     (busy_set),
      .busy_clr     (busy_clr),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clkin = ~clkin;

   always @(negedge clkin) begin
      if (busy_set === 1'b1) bset_cyc <= bset_cyc + 1;
      if (busy_clr === 1'b1) bclr_cyc <= bclr_cyc + 1;
      if ((mcu_req === 1'b1) && req_prev &&
          ((fill_addr !== lat_addr) || (fill_half !== lat_half)))
         stab_err <= stab_err + 1;
      req_prev <= (mcu_req === 1'b1);
      lat_addr <= fill_addr;
      lat_half <= fill_half;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clkin);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input logic lvl, input int budget, input string tag);
      int n = 0;
      while ((mcu_req !== lvl) && (n < budget)) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, {31'h0, mcu_req}, {31'h0, lvl});
   endtask

   task automatic serve(input logic exp_half, input logic [31:0] exp_addr,
                        input int delay, input string tag);
      wait_req(1'b1, 200, tag);
      chk({tag, "_half"}, {31'h0, fill_half}, {31'h0, exp_half});
      chk({tag, "_addr"}, fill_addr, exp_addr);
      repeat (delay) tick();
      mcu_ack = 1'b1;
      wait_req(1'b0, 50, {tag, "_drop"});
      repeat (delay) tick();
      mcu_ack = 1'b0;
   endtask

   task automatic do_seek(input logic [31:0] a);
      seek_addr  = a;
      seek_start = 1'b1;
      tick();
      tick();
      seek_start = 1'b0;
   endtask

   task automatic refill(input string tag);
      logic v;
      repeat (4 + $urandom_range(0, 4)) tick();
      v       = rd_half;
      rd_half = ~rd_half;
      serve(v, mn, $urandom_range(0, 6), tag);
      mn = mn + H;
   endtask

   task automatic no_req(input int cycles, input string tag);
      logic s = 1'b0;
      repeat (cycles) begin
         tick();
         s = s | (mcu_req === 1'b1);
      end
      chk(tag, {31'h0, s}, 32'h0);
   endtask

   initial begin
`ifdef MSU_UNDERRUN_CNT_EN
      exp_cnt1 = 8'd1;
      exp_sat  = 8'd255;
`else
      exp_cnt1 = 8'd0;
      exp_sat  = 8'd0;
`endif
      rst_n = 1'b0; enable = 1'b0; seek_start = 1'b0; seek_addr = 32'h0;
      rd_half = 1'b0; mcu_ack = 1'b0;
      repeat (3) tick();
      chk("rst_req", {31'h0, mcu_req}, 32'h0);
      chk("rst_half", {31'h0, fill_half}, 32'h0);
      chk("rst_addr", fill_addr, 32'h0);
      chk("rst_bset", {31'h0, busy_set}, 32'h0);
      chk("rst_bclr", {31'h0, busy_clr}, 32'h0);
      chk("rst_urun", {31'h0, underrun}, 32'h0);
      chk("rst_ucnt", {24'h0, underrun_cnt}, 32'h0);
      rst_n = 1'b1; enable = 1'b1;
      tick();

      // initial two-half fill after a seek
      bs0 = bset_cyc; bc0 = bclr_cyc;
      mn = 32'h0001_0000;
      do_seek(mn);
      serve(1'b0, mn, 10, "seek_f0"); mn = mn + H;
      serve(1'b1, mn, 10, "seek_f1"); mn = mn + H;
      repeat (6) tick();
      chk("seek_bset", bset_cyc, bs0 + 1);
      chk("seek_bclr", bclr_cyc, bc0 + 1);

      refill("rf_a");
      chk("rf_next", mn, 32'h0001_6000);
      refill("rf_b");
      for (int i = 0; i < 6; i++) refill("rf_rand");
      repeat (4) tick();
      chk("rf_no_urun", {31'h0, underrun}, 32'h0);

      // two toggles during one refill: one underrun, one pending refill
      repeat (5) tick();
      vac = rd_half; rd_half = ~rd_half;
      wait_req(1'b1, 50, "ur");
      chk("ur_half", {31'h0, fill_half}, {31'h0, vac});
      chk("ur_addr", fill_addr, mn);
      repeat (3) tick(); rd_half = ~rd_half;
      repeat (3) tick(); rd_half = ~rd_half;
      repeat (3) tick();
      mcu_ack = 1'b1;
      wait_req(1'b0, 50, "ur_drop");
      tick();
      mcu_ack = 1'b0;
      mn = mn + H;
      repeat (2) tick();
      chk("ur_flag", {31'h0, underrun}, 32'h1);
      chk("ur_cnt", {24'h0, underrun_cnt}, {24'h0, exp_cnt1});
      serve(~rd_half, mn, 3, "ur_pend"); mn = mn + H;

      // many underruns in one refill: counter saturates
      repeat (5) tick();
      vac = rd_half; rd_half = ~rd_half;
      wait_req(1'b1, 50, "sat");
      chk("sat_half", {31'h0, fill_half}, {31'h0, vac});
      for (int i = 0; i < 300; i++) begin
         rd_half = ~rd_half; repeat (2) tick();
         rd_half = ~rd_half; repeat (2) tick();
      end
      mcu_ack = 1'b1;
      wait_req(1'b0, 50, "sat_drop");
      tick();
      mcu_ack = 1'b0;
      mn = mn + H;
      repeat (2) tick();
      chk("sat_flag", {31'h0, underrun}, 32'h1);
      chk("sat_cnt", {24'h0, underrun_cnt}, {24'h0, exp_sat});
      serve(~rd_half, mn, 1, "sat_pend"); mn = mn + H;

      // seek while a refill request is outstanding
      repeat (5) tick();
      vac = rd_half; rd_half = ~rd_half;
      wait_req(1'b1, 50, "drn");
      chk("drn_old_addr", fill_addr, mn);
      bs0 = bset_cyc;
      nb = $urandom;
      do_seek(nb);
      chk("drn_urun_clr", {31'h0, underrun}, 32'h0);
      chk("drn_ucnt_clr", {24'h0, underrun_cnt}, 32'h0);
      chk("drn_req_held", {31'h0, mcu_req}, 32'h1);
      mcu_ack = 1'b1;
      wait_req(1'b0, 50, "drn_drop");
      repeat (2) tick();
      mcu_ack = 1'b0;
      mn = nb;
      serve(1'b0, mn, 4, "drn_f0"); mn = mn + H;
      serve(1'b1, mn, 4, "drn_f1"); mn = mn + H;
      chk("drn_bset", bset_cyc, bs0 + 1);
      refill("drn_rf");

      // file offset wraps at 2^32
      repeat (5) tick();
      mn = 32'hFFFF_E000;
      do_seek(mn);
      serve(1'b0, mn, 2, "wrap_f0"); mn = mn + H;
      serve(1'b1, mn, 2, "wrap_f1"); mn = mn + H;
      chk("wrap_next", mn, 32'h0000_2000);
      refill("wrap_rf");

      // random seek offset with refills
      repeat (5) tick();
      mn = $urandom;
      do_seek(mn);
      serve(1'b0, mn, $urandom_range(0, 5), "rs_f0"); mn = mn + H;
      serve(1'b1, mn, $urandom_range(0, 5), "rs_f1"); mn = mn + H;
      for (int i = 0; i < 3; i++) refill("rs_rf");

      // feature disabled: no requests, seeks ignored
      repeat (5) tick();
      enable = 1'b0;
      repeat (4) tick();
      rd_half = ~rd_half;
      no_req(20, "dis_no_refill");
      bs0 = bset_cyc;
      do_seek(32'h1234_0000);
      no_req(10, "dis_no_seek_req");
      chk("dis_bset", bset_cyc, bs0);
      enable = 1'b1;
      repeat (3) tick();

      // reset in the middle of the second seek fill
      mn = 32'h0008_0000;
      do_seek(mn);
      serve(1'b0, mn, 3, "mr_f0"); mn = mn + H;
      wait_req(1'b1, 50, "mr_f1");
      chk("mr_f1_half", {31'h0, fill_half}, 32'h1);
      rst_n = 1'b0;
      tick();
      chk("mr_req", {31'h0, mcu_req}, 32'h0);
      chk("mr_half", {31'h0, fill_half}, 32'h0);
      chk("mr_addr", fill_addr, 32'h0);
      chk("mr_bset", {31'h0, busy_set}, 32'h0);
      chk("mr_bclr", {31'h0, busy_clr}, 32'h0);
      chk("mr_urun", {31'h0, underrun}, 32'h0);
      chk("mr_ucnt", {24'h0, underrun_cnt}, 32'h0);
      rst_n = 1'b1;
      no_req(20, "mr_idle");

      chk("fill_stable", stab_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/msu_fill_sched.md
# msu_fill_sched

Double-buffer refill scheduler for the 16 KiB MSU data buffer. It tracks the SNES read position, which is bit 13 of the MSU data address and selects the active 8 KiB half. When the SNES moves into one half, the scheduler asks the MCU to refill the other half from the next file offset. It also sequences the initial two-half fill after a data seek, drives data-busy set/reset requests into the MSU status logic, and flags underruns.

## Interface
Parameters:
- HALF_BYTES, 8192: bytes per buffer half; the file-offset increment per fill.
- ADDR_W, 32: file offset width.

Ports:
- clkin  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  MSU feature enable; when low, no new requests are issued.
- seek_start  in  1  level data-seek flag from the MSU register block; a rising edge starts a seek.
- seek_addr  in  ADDR_W  file offset written by the SNES; sampled on the seek edge.
- rd_half  in  1  bit 13 of the SNES-side buffer read address.
- mcu_ack  in  1  MCU fill acknowledge, 4-phase; asynchronous to clkin.
- mcu_req  out  1  fill request, 4-phase.
- fill_half  out  1  buffer half to fill; stable while mcu_req=1.
- fill_addr  out  ADDR_W  file offset for the fill; stable while mcu_req=1.
- busy_set  out  1  one-cycle pulse that sets data_busy.
- busy_clr  out  1  one-cycle pulse that clears data_busy and data_start.
- underrun  out  1  sticky underrun flag; cleared by the next seek.
- underrun_cnt  out  8  saturating underrun count (see Configuration).

## Operation
- mcu_ack passes through a 2-flop synchronizer; all logic uses the synchronized ack_s.
- Handshake, per fill:
  - Raise mcu_req with fill_half/fill_addr valid.
  - Wait for ack_s=1, then drop mcu_req.
  - Wait for ack_s=0; the fill is then complete.
- FSM states: IDLE, SEEK0, SEEK1, STREAM, REFILL, DRAIN.
- IDLE:
  - On a seek edge with enable=1: pulse busy_set, latch next_addr=seek_addr, clear underrun, go to SEEK0.
- SEEK0: fill half 0 at next_addr; on completion next_addr+=HALF_BYTES, go to SEEK1.
- SEEK1: fill half 1 at next_addr; on completion next_addr+=HALF_BYTES, pulse busy_clr, latch cur_half=rd_half, go to STREAM.
- STREAM:
  - When rd_half≠cur_half, set pend_half=cur_half and cur_half=rd_half, then go to REFILL.
  - The half just vacated is the one to refill.
- REFILL: fill pend_half at next_addr; on completion next_addr+=HALF_BYTES, go to STREAM.
- Underrun:
  - Condition: rd_half toggles again while in REFILL, meaning the SNES has re-entered the half being filled.
  - Action: set underrun and increment the counter.
  - The toggle is recorded in a 1-deep pending flag and serviced on return to STREAM.
  - Further toggles while the flag is already set count as underruns only.
- Seek during SEEK0/SEEK1/REFILL:
  - Pulse busy_set and latch the new seek_addr.
  - If mcu_req=1 or ack_s=1, go to DRAIN: finish the 4-phase cycle without starting another, then go to SEEK0.
  - Otherwise go to SEEK0 directly.
  - A seek in STREAM goes to SEEK0 directly.
- enable=0:
  - The FSM completes any in-flight handshake, then returns to IDLE.
  - Pending toggles are discarded.
- next_addr wraps modulo 2^ADDR_W.

## Timing
- Reset values: all outputs 0; FSM=IDLE; next_addr=0; cur_half=0; pending flag 0; synchronizer and edge registers 0.
- Seek edge detect: seek_start is registered; the edge is seen 1 cycle after the rise.
  - busy_set pulses in the cycle the FSM leaves IDLE.
  - mcu_req rises on the following cycle. It is registered, asserted 1 cycle after state entry.
- ack latency: a mcu_ack edge is visible to the FSM 2 cycles later.
  - mcu_req falls 1 cycle after ack_s=1.
  - The next mcu_req may rise no earlier than 1 cycle after ack_s=0.
- busy_clr pulses in the cycle SEEK1 completes; STREAM is entered the next cycle.
- rd_half toggle: registered, so detection takes 1 cycle. mcu_req for the refill rises 2 cycles after the toggle.
- Simultaneous seek edge and fill completion: the seek wins; no next_addr increment; go to SEEK0.
- Simultaneous seek edge and enable=0: enable wins; the seek is ignored.
- Reset mid-handshake: mcu_req drops immediately. The MCU side tolerates an abandoned cycle.

## Configuration
- MSU_UNDERRUN_CNT_EN defined: underrun_cnt is an 8-bit counter that saturates at 255 and is cleared on a seek.
- MSU_UNDERRUN_CNT_EN undefined: underrun_cnt is tied to 8'h00; the sticky underrun flag remains.

## Structure
- Package msu_pkg:
  - FSM state enum msu_fill_state_t;
  - HALF_BYTES_DEFAULT=8192;
  - ADDR_W_DEFAULT=32.
- One sub-module, msu_ack_sync: 2-flop synchronizer plus rising/falling ack_s strobes; reset via rst_n.

## Test plan
- Seek, seek_addr=0x00010000, MCU acks after 10 cycles → busy_set pulse; fills half 0 @0x10000, then half 1 @0x12000; busy_clr pulse; STREAM.
- In STREAM with cur_half=0, rd_half 0→1 → mcu_req, fill_half=0, fill_addr=0x14000; next_addr then 0x16000.
- During REFILL, rd_half toggles twice before ack → underrun=1; underrun_cnt=1 (MSU_UNDERRUN_CNT_EN); one pending refill serviced after completion.
- Seek in REFILL while mcu_req=1 and ack not yet seen → DRAIN completes the cycle; SEEK0 issues fill @new seek_addr; underrun cleared.
- seek_addr=0xFFFFE000 → second fill at 0xFFFFE000+0x2000=0x00000000 (wrap).
- rst_n=0 for 1 cycle mid-SEEK1 with mcu_req=1 → next cycle: mcu_req=0, all outputs 0, FSM IDLE.
